// File: rtl/rtc_time_counter.sv
// rtl/rtc_time_counter.sv - BCD HH:MM:SS time-of-day counter with 1 Hz prescaler
// Optional hourly chime output is enabled by defining RTC_CHIME_EN.
module rtc_time_counter #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic       set_load,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic [7:0] cur_hh,
   output logic [7:0] cur_mm,
   output logic [7:0] cur_ss,
   output logic       sec_p,
   output logic       blink_on
`ifdef RTC_CHIME_EN
   ,
   output logic       chime
`endif
);

   localparam int            PW   = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [7:0]    hh_q, hh_d;
   logic [7:0]    mm_q, mm_d;
   logic [7:0]    ss_q, ss_d;
   logic          sec_p_q, sec_p_d;
   logic          tick;
   logic          advance;

   // A field is loadable only if both digits are decimal and the value is in range.
   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'h0};
      end
      return v + 8'd1;
   endfunction

   always_comb begin
      tick    = (pcnt_q == PMAX);
      advance = tick && !set_en && !set_load;
      pcnt_d  = (set_load || tick) ? '0 : pcnt_q + 1'b1;
      hh_d    = hh_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      sec_p_d = advance;
      if (set_load) begin
         hh_d = bcd_ok(set_hh, 8'h23) ? set_hh : 8'h00;
         mm_d = bcd_ok(set_mm, 8'h59) ? set_mm : 8'h00;
         ss_d = bcd_ok(set_ss, 8'h59) ? set_ss : 8'h00;
      end else if (advance) begin
         if (ss_q == 8'h59) begin
            ss_d = 8'h00;
            if (mm_q == 8'h59) begin
               mm_d = 8'h00;
               hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
            end else begin
               mm_d = bcd_inc(mm_q);
            end
         end else begin
            ss_d = bcd_inc(ss_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q  <= '0;
         hh_q    <= 8'h12;
         mm_q    <= 8'h00;
         ss_q    <= 8'h00;
         sec_p_q <= 1'b0;
      end else begin
         pcnt_q  <= pcnt_d;
         hh_q    <= hh_d;
         mm_q    <= mm_d;
         ss_q    <= ss_d;
         sec_p_q <= sec_p_d;
      end
   end

`ifdef RTC_CHIME_EN
   logic chime_q, chime_d;

   // Raised only by an advance onto the hour; loads and holds silence it.
   always_comb begin
      chime_d = chime_q;
      if (set_load || set_en) begin
         chime_d = 1'b0;
      end else if (advance) begin
         chime_d = (mm_d == 8'h00) && (ss_d == 8'h00);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chime_q <= 1'b0;
      end else begin
         chime_q <= chime_d;
      end
   end

   assign chime = chime_q;
`endif

   assign cur_hh   = hh_q;
   assign cur_mm   = mm_q;
   assign cur_ss   = ss_q;
   assign sec_p    = sec_p_q;
   assign blink_on = (pcnt_q < HALF);

endmodule

// File: tb/tb_rtc_time_counter.sv
// tb/tb_rtc_time_counter.sv - randomized self-checking bench for rtc_time_counter
// Reference model keeps time as seconds-of-day; build with RTC_CHIME_EN to cover chime.
module tb_rtc_time_counter;

   localparam int HZ = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       set_en = 1'b0;
   logic       set_load = 1'b0;
   logic [7:0] set_hh = 8'h00;
   logic [7:0] set_mm = 8'h00;
   logic [7:0] set_ss = 8'h00;
   logic [7:0] cur_hh, cur_mm, cur_ss;
   logic       sec_p, blink_on;
`ifdef RTC_CHIME_EN
   logic       chime;
`endif

   rtc_time_counter #(.CLK_HZ(HZ)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (set_en),
      .set_load (set_load),
      .set_hh   (set_hh),
      .set_mm   (set_mm),
      .set_ss   (set_ss),
      .cur_hh   (cur_hh),
      .cur_mm   (cur_mm),
      .cur_ss   (cur_ss),
      .sec_p    (sec_p),
      .blink_on (blink_on)
`ifdef RTC_CHIME_EN
      ,
      .chime    (chime)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   int m_sec;
   int m_pcnt;
   bit m_secp;
   bit m_chime;

   function automatic int bcd_val(input logic [7:0] v, input int max);
      int t, u;
      t = int'(v[7:4]);
      u = int'(v[3:0]);
      if (t > 9 || u > 9 || t * 10 + u > max) return 0;
      return t * 10 + u;
   endfunction

   function automatic logic [7:0] to_bcd(input int n);
      return 8'((n / 10) * 16 + (n % 10));
   endfunction

   function automatic logic [23:0] exp_time();
      return {to_bcd(m_sec / 3600), to_bcd((m_sec / 60) % 60), to_bcd(m_sec % 60)};
   endfunction

   task automatic model_reset();
      m_sec   = 12 * 3600;
      m_pcnt  = 0;
      m_secp  = 0;
      m_chime = 0;
   endtask

   // One rising edge: apply the model's rules to the inputs present at the edge.
   task automatic step();
      bit tick;
      @(posedge clk);
      if (set_load) begin
         m_sec   = bcd_val(set_hh, 23) * 3600 + bcd_val(set_mm, 59) * 60 + bcd_val(set_ss, 59);
         m_pcnt  = 0;
         m_secp  = 0;
         m_chime = 0;
      end else begin
         tick   = (m_pcnt == HZ - 1);
         m_pcnt = (m_pcnt + 1) % HZ;
         m_secp = tick && !set_en;
         if (m_secp) begin
            m_sec   = (m_sec + 1) % 86400;
            m_chime = (m_sec % 3600 == 0);
         end
         if (set_en) m_chime = 0;
      end
      #1;
   endtask

   task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      set_hh = h;
      set_mm = m;
      set_ss = s;
      set_load = 1'b1;
      step();
      set_load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({cur_hh, cur_mm, cur_ss, sec_p, blink_on} !== {24'h120000, 1'b0, 1'b1})
         $display("FAIL reset_state got %h %b %b want 120000 0 1", {cur_hh, cur_mm, cur_ss}, sec_p, blink_on);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== exp_time() || sec_p !== m_secp || blink_on !== (m_pcnt < HZ / 2))
            $display("FAIL first_second c%0d got %h %b %b want %h %b %b", i, {cur_hh, cur_mm, cur_ss},
                     sec_p, blink_on, exp_time(), m_secp, m_pcnt < HZ / 2);
         else n_pass++;
      end
      n_total++;
      if (cur_ss !== 8'h02) $display("FAIL first_second_ss got %h want 02", cur_ss);
      else n_pass++;
   endtask

   task automatic test_rollover();
      load(8'h23, 8'h59, 8'h59);
      for (int i = 0; i < 9; i++) begin
         step();
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== exp_time() || sec_p !== m_secp)
            $display("FAIL rollover c%0d got %h %b want %h %b", i, {cur_hh, cur_mm, cur_ss}, sec_p, exp_time(), m_secp);
         else n_pass++;
`ifdef RTC_CHIME_EN
         n_total++;
         if (chime !== m_chime) $display("FAIL rollover_chime c%0d got %b want %b", i, chime, m_chime);
         else n_pass++;
`endif
         if (i == 3) begin
            n_total++;
            if ({cur_hh, cur_mm, cur_ss} !== 24'h000000) $display("FAIL rollover_midnight got %h want 000000", {cur_hh, cur_mm, cur_ss});
            else n_pass++;
         end
      end
   endtask

   task automatic test_digit_carry();
      logic [23:0] want [2];
      want[0] = 24'h090910;
      want[1] = 24'h100000;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) load(8'h09, 8'h09, 8'h09);
         else load(8'h09, 8'h59, 8'h59);
         repeat (HZ) step();
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== want[k] || {cur_hh, cur_mm, cur_ss} !== exp_time() || sec_p !== 1'b1)
            $display("FAIL digit_carry%0d got %h %b want %h 1", k, {cur_hh, cur_mm, cur_ss}, sec_p, want[k]);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      logic [23:0] held;
      int pulses = 0, blinks = 0;
      held = {cur_hh, cur_mm, cur_ss};
      set_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (sec_p) pulses++;
         if (blink_on) blinks++;
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== held || blink_on !== (m_pcnt < HZ / 2))
            $display("FAIL hold c%0d got %h %b want %h %b", i, {cur_hh, cur_mm, cur_ss}, blink_on, held, m_pcnt < HZ / 2);
         else n_pass++;
      end
      n_total++;
      if (pulses != 0 || blinks != 10) $display("FAIL hold_pulses got %0d/%0d want 0/10", pulses, blinks);
      else n_pass++;
      set_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== exp_time() || sec_p !== m_secp)
            $display("FAIL hold_release c%0d got %h %b want %h %b", i, {cur_hh, cur_mm, cur_ss}, sec_p, exp_time(), m_secp);
         else n_pass++;
      end
   endtask

   task automatic test_load_on_tick();
      int guard = 0;
      while (m_pcnt != HZ - 1 && guard < 2 * HZ) begin
         step();
         guard++;
      end
      n_total++;
      if (m_pcnt != HZ - 1) $display("FAIL tick_align got %0d want %0d", m_pcnt, HZ - 1);
      else n_pass++;
      load(8'h14, 8'h3A, 8'h75);
      n_total++;
      if ({cur_hh, cur_mm, cur_ss} !== 24'h140000 || sec_p !== 1'b0)
         $display("FAIL load_on_tick got %h %b want 140000 0", {cur_hh, cur_mm, cur_ss}, sec_p);
      else n_pass++;
      for (int i = 1; i <= HZ; i++) begin
         step();
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== (i == HZ ? 24'h140001 : 24'h140000) || sec_p !== (i == HZ))
            $display("FAIL post_load e%0d got %h %b want %h %b", i, {cur_hh, cur_mm, cur_ss}, sec_p,
                     (i == HZ ? 24'h140001 : 24'h140000), i == HZ);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(15) == 0) set_en = ~set_en;
         if ($urandom_range(19) == 0) begin
            case ($urandom_range(2))
               0: begin set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom); end
               1: begin set_hh = to_bcd($urandom_range(23)); set_mm = to_bcd($urandom_range(59)); set_ss = to_bcd($urandom_range(59)); end
               default: begin set_hh = to_bcd($urandom_range(23)); set_mm = 8'h59; set_ss = 8'h58; end
            endcase
            set_load = 1'b1;
         end
         step();
         set_load = 1'b0;
         n_total++;
         if ({cur_hh, cur_mm, cur_ss} !== exp_time() || sec_p !== m_secp || blink_on !== (m_pcnt < HZ / 2)
`ifdef RTC_CHIME_EN
             || chime !== m_chime
`endif
            ) begin
            errs++;
            if (errs <= 5)
               $display("FAIL random c%0d got %h %b %b want %h %b %b", i, {cur_hh, cur_mm, cur_ss}, sec_p,
                        blink_on, exp_time(), m_secp, m_pcnt < HZ / 2);
         end else n_pass++;
      end
      set_en = 1'b0;
   endtask

   task automatic test_async_reset();
      load(8'h05, 8'h06, 8'h07);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_total++;
      if ({cur_hh, cur_mm, cur_ss, sec_p, blink_on} !== {24'h120000, 1'b0, 1'b1})
         $display("FAIL async_reset got %h %b %b want 120000 0 1", {cur_hh, cur_mm, cur_ss}, sec_p, blink_on);
      else n_pass++;
`ifdef RTC_CHIME_EN
      n_total++;
      if (chime !== 1'b0) $display("FAIL async_reset_chime got %b want 0", chime);
      else n_pass++;
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (HZ) step();
      n_total++;
      if ({cur_hh, cur_mm, cur_ss} !== 24'h120001 || sec_p !== 1'b1)
         $display("FAIL after_reset got %h %b want 120001 1", {cur_hh, cur_mm, cur_ss}, sec_p);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rollover();
      test_digit_carry();
      test_hold();
      test_load_on_tick();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rtc_time_counter.md
# rtc_time_counter

Free-running BCD time-of-day counter that sits directly downstream of the time-setting FSM. It divides the system clock down to a 1 Hz tick and advances HH:MM:SS in packed BCD. It freezes while the setter holds `set_en` and loads the setter's values on `set_load`. Its `cur_*` outputs feed both the display path and the setter's "load current time" input, and it supplies the half-second blink phase used when flashing the selected field.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: system clock cycles per second. Must be ≥ 2 and even.

Ports:
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `set_en` input 1: level. While 1, time does not advance.
- `set_load` input 1: one-cycle pulse. Loads `set_hh/mm/ss`.
- `set_hh` input 8: BCD hours to load.
- `set_mm` input 8: BCD minutes to load.
- `set_ss` input 8: BCD seconds to load.
- `cur_hh` output 8: current hours, BCD 00–23.
- `cur_mm` output 8: current minutes, BCD 00–59.
- `cur_ss` output 8: current seconds, BCD 00–59.
- `sec_p` output 1: one-cycle pulse on each second advance.
- `blink_on` output 1: blink phase, 1 during the first half of each second.
- `chime` output 1: only present with `RTC_CHIME_EN` (see Configuration).

## Operation
- **Prescaler `pcnt`**
  - Counts 0..CLK_HZ-1, then wraps to 0.
  - Runs regardless of `set_en`.
  - Internal tick = (`pcnt == CLK_HZ-1`).
- **Priority per edge:** `rst_n` > `set_load` > tick advance > hold.
- **Load** (`set_load == 1`)
  - Each field is validated independently: a digit > 9, hh > 0x23, or mm/ss > 0x59 loads 0x00 for that field; valid fields load unchanged.
  - `pcnt` is cleared to 0 on the same edge.
  - No advance and no `sec_p` on that edge.
  - Load is honoured whether `set_en` is 0 or 1.
- **Advance** (tick && `set_en == 0` && `set_load == 0`)
  - ss is BCD-incremented.
  - ss 0x59 → 0x00 and mm increments.
  - mm 0x59 → 0x00 and hh increments.
  - hh 0x23 → 0x00, so 23:59:59 → 00:00:00.
  - Units digit 9 → 0 with a carry into the tens digit.
- **Hold:** a tick with `set_en == 1` is discarded; there is no deferred catch-up.
- **`sec_p`**
  - Registered; high for exactly the one cycle in which the newly advanced `cur_ss` first appears.
  - Never high on a load edge or while held.
- **`blink_on`:** combinational, = (`pcnt < CLK_HZ/2`).

## Timing
- **Reset values**
  - `cur_hh` = 0x12, `cur_mm` = 0x00, `cur_ss` = 0x00.
  - `pcnt` = 0, `sec_p` = 0, `blink_on` = 1, `chime` = 0.
- **First advance:** after reset release, `cur_ss` becomes 0x01 (and `sec_p` = 1) after the CLK_HZ-th rising edge.
- **Load latency**
  - `set_load` sampled at edge N: `cur_*` show the loaded values after edge N.
  - The next advance occurs at edge N + CLK_HZ, provided `set_en` is 0 by then.
- **Reset mid-operation** returns to the reset values immediately (asynchronously); a load in progress is lost.
- **Coincident events**
  - `set_load` on a tick edge: load wins.
  - `set_en` rising on a tick edge: no advance.
- **Combinational paths:** none from inputs to outputs. All outputs are registered except `blink_on`, which is decoded from `pcnt`.

## Configuration
- **`RTC_CHIME_EN` defined**
  - Adds the `chime` output port.
  - `chime` goes to 1 on the edge where an advance produces mm = 0x00, ss = 0x00.
  - It stays 1 until the next advance, i.e. one second.
  - It is cleared immediately by `set_load` or `set_en == 1`.
  - A load of xx:00:00 does not raise `chime`.
- **`RTC_CHIME_EN` undefined:** the `chime` port and all its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use CLK_HZ = 4.
- **Reset and first second:** release reset → `cur` = 12:00:00, `blink_on` = 1 for 2 cycles then 0 for 2; after the 4th edge `cur_ss` = 0x01 and `sec_p` is a single-cycle pulse.
- **Full rollover:** load 23:59:59 with `set_en` = 0 → after 4 edges `cur` = 00:00:00 with one `sec_p`; with `RTC_CHIME_EN`, `chime` = 1 for the following 4 cycles.
- **Digit carry:** load 09:09:09 → next advance gives 09:09:10; load 09:59:59 → next advance gives 10:00:00.
- **Hold:** hold `set_en` = 1 for 20 cycles → `cur` unchanged, `sec_p` never 1, `blink_on` keeps toggling; after release, advances resume on the next tick.
- **Load on tick edge / invalid load:**
  - Assert `set_load` with 14:3A:75 exactly when `pcnt` = 3 → `cur` = 14:00:00, no `sec_p`.
  - Next advance occurs exactly 4 edges later.
- **Async reset mid-run:** assert `rst_n` = 0 between edges at 05:06:07 → outputs return to reset values without waiting for a clock edge.
